// File: rtl/railway_gate_ctrl_mt_if.sv
// Field-side bundle of the level-crossing controller: track/gate sensors in,
// lamp and motor drives plus status out.
interface railway_gate_ctrl_mt_if #(
    parameter int N_TRACKS = 2
);
    logic [N_TRACKS-1:0] approach;
    logic [N_TRACKS-1:0] exit_det;
    logic                gate_down_fb;
    logic                gate_up_fb;
    logic                maint_req;
    logic                fault_clr;
    logic                warn_led;
    logic                close_cmd;
    logic                open_cmd;
    logic                closed_led;
    logic                fault;
    logic                busy;
    logic [2:0]          state_o;

    modport master (
        output approach, exit_det, gate_down_fb, gate_up_fb, maint_req, fault_clr,
        input  warn_led, close_cmd, open_cmd, closed_led, fault, busy, state_o
    );

    modport slave (
        input  approach, exit_det, gate_down_fb, gate_up_fb, maint_req, fault_clr,
        output warn_led, close_cmd, open_cmd, closed_led, fault, busy, state_o
    );
endinterface

// File: rtl/railway_gate_ctrl_mt.sv
// Multi-track level-crossing gate controller: per-track occupancy counting,
// warn/close/hold/open sequencing and motor-feedback supervision with latched FAULT.

module railway_gate_trk_occ #(
    parameter int OCC_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             approach,
    input  logic             exit_det,
    output logic [OCC_W-1:0] occ_o
);
    logic             app_prev_q, app_prev_d;
    logic             ext_prev_q, ext_prev_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             app_rise, ext_rise;

    always_comb begin
        app_rise   = approach & ~app_prev_q;
        ext_rise   = exit_det & ~ext_prev_q;
        app_prev_d = approach;
        ext_prev_d = exit_det;
        occ_d      = occ_q;
        // Simultaneous entry and exit on one track cancel out.
        if (app_rise && !ext_rise && (occ_q != '1))
            occ_d = occ_q + OCC_W'(1);
        else if (ext_rise && !app_rise && (occ_q != '0))
            occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            app_prev_q <= 1'b0;
            ext_prev_q <= 1'b0;
            occ_q      <= '0;
        end else begin
            app_prev_q <= app_prev_d;
            ext_prev_q <= ext_prev_d;
            occ_q      <= occ_d;
        end
    end

    assign occ_o = occ_q;
endmodule

module railway_gate_ctrl_mt #(
    parameter int N_TRACKS       = 2,
    parameter int OCC_W          = 3,
    parameter int TMR_W          = 16,
    parameter int ALERT_CYCLES   = 10,
    parameter int CLEAR_CYCLES   = 4,
    parameter int MOTION_TIMEOUT = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    railway_gate_ctrl_mt_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ALERT      = 3'd1,
        S_CLOSING    = 3'd2,
        S_CLOSED     = 3'd3,
        S_HOLD_CLEAR = 3'd4,
        S_OPENING    = 3'd5,
        S_FAULT      = 3'd6
    } state_e;

    localparam logic [TMR_W-1:0] ALERT_LAST  = TMR_W'(ALERT_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLEAR_LAST  = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMR_W-1:0] MOTION_LAST = TMR_W'(MOTION_TIMEOUT - 1);

    logic [N_TRACKS-1:0][OCC_W-1:0] occ;
    logic [N_TRACKS-1:0]            trk_nz;
    logic                           busy;
    state_e                         state_q, state_d;
    logic [TMR_W-1:0]               timer_q, timer_d;

    for (genvar i = 0; i < N_TRACKS; i++) begin : g_trk
        railway_gate_trk_occ #(.OCC_W(OCC_W)) u_occ (
            .clk      (clk),
            .reset_n  (reset_n),
            .approach (bus.approach[i]),
            .exit_det (bus.exit_det[i]),
            .occ_o    (occ[i])
        );
        assign trk_nz[i] = |occ[i];
    end

    assign busy = (|trk_nz) | bus.maint_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (busy) state_d = S_ALERT;
            S_ALERT:      if (timer_q == ALERT_LAST) state_d = S_CLOSING;
            S_CLOSING: begin
                if (bus.gate_down_fb)            state_d = S_CLOSED;
                else if (timer_q == MOTION_LAST) state_d = S_FAULT;
            end
            S_CLOSED:     if (!busy) state_d = S_HOLD_CLEAR;
            S_HOLD_CLEAR: begin
                if (busy)                       state_d = S_CLOSED;
                else if (timer_q == CLEAR_LAST) state_d = S_OPENING;
            end
            S_OPENING: begin
                // A train arriving while the gate rises re-closes it at once.
                if (busy)                        state_d = S_CLOSING;
                else if (bus.gate_up_fb)         state_d = S_IDLE;
                else if (timer_q == MOTION_LAST) state_d = S_FAULT;
            end
            S_FAULT:      if (bus.fault_clr && !busy) state_d = S_OPENING;
            default:      state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q == '1)
            timer_d = timer_q;
        else
            timer_d = timer_q + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        bus.warn_led   = 1'b0;
        bus.close_cmd  = 1'b0;
        bus.open_cmd   = 1'b0;
        bus.closed_led = 1'b0;
        bus.fault      = 1'b0;
        case (state_q)
            S_ALERT:      bus.warn_led = 1'b1;
            S_CLOSING:    begin bus.warn_led = 1'b1; bus.close_cmd = 1'b1; end
            S_CLOSED,
            S_HOLD_CLEAR: begin bus.warn_led = 1'b1; bus.closed_led = 1'b1; end
            S_OPENING:    begin bus.warn_led = 1'b1; bus.open_cmd = 1'b1; end
            // Fail-safe: keep driving the gate down while faulted.
            S_FAULT:      begin bus.warn_led = 1'b1; bus.close_cmd = 1'b1; bus.fault = 1'b1; end
            default:      ;
        endcase
    end

    assign bus.busy    = busy;
    assign bus.state_o = state_q;
endmodule
